// File: rtl/nfifo2mem_if.sv
// Bundle of the write, read, release and status signals of nfifo2mem.
// The master drives requests; the slave (the buffer) returns flags and read data.
interface nfifo2mem_if #(
    parameter int DATA_WIDTH = 64,
    parameter int FLOWS      = 8,
    parameter int BLOCK_SIZE = 512
);
    localparam int FW = DATA_WIDTH / FLOWS;
    localparam int AW = $clog2(BLOCK_SIZE);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(FLOWS);

    logic [DATA_WIDTH-1:0] data_in;
    logic [FLOWS-1:0]      write;
    logic [FLOWS-1:0]      full;
    logic [BW-1:0]         block_addr;
    logic [AW-1:0]         rd_addr;
    logic                  read;
    logic [FW-1:0]         data_out;
    logic                  data_vld;
    logic [BW-1:0]         rel_block;
    logic [CW-1:0]         rel_len;
    logic                  rel_len_dv;
    logic [FLOWS-1:0]      empty;
    logic [FLOWS*CW-1:0]   status;

    modport master (
        output data_in, write, block_addr, rd_addr, read, rel_block, rel_len, rel_len_dv,
        input  full, data_out, data_vld, empty, status
    );

    modport slave (
        input  data_in, write, block_addr, rd_addr, read, rel_block, rel_len, rel_len_dv,
        output full, data_out, data_vld, empty, status
    );
endinterface

// File: rtl/nfifo2mem.sv
// FLOWS independent circular buffers written in parallel, read at a random
// offset from one shared port (1-cycle latency) and freed in variable-size chunks.
module nfifo2mem #(
    parameter int DATA_WIDTH = 64,
    parameter int FLOWS      = 8,
    parameter int BLOCK_SIZE = 512,
    parameter int LUT_MEMORY = 0,
    parameter int GLOB_STATE = 0
) (
    input logic        clk,
    input logic        rst_n,
    nfifo2mem_if.slave bus
);
    localparam int FW = DATA_WIDTH / FLOWS;
    localparam int AW = $clog2(BLOCK_SIZE);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(FLOWS);

    logic [FLOWS-1:0]         full_loc;
    logic [FLOWS-1:0][CW-1:0] cnt_all;
    logic [FLOWS-1:0][FW-1:0] rd_word;
    logic                     rd_ok;
    logic                     data_vld_q;

    // Range check uses the occupancy before this cycle's writes and releases.
    assign rd_ok = rst_n & bus.read & ({1'b0, bus.rd_addr} < cnt_all[bus.block_addr]);

    for (genvar i = 0; i < FLOWS; i++) begin : g_flow
        logic [AW-1:0] wr_ptr;
        logic [AW-1:0] rd_ptr;
        logic [CW-1:0] cnt;
        logic [CW-1:0] rel_amt;
        logic [AW-1:0] rd_idx;
        logic          wr_acc;
        logic          rel_hit;
        logic [FW-1:0] mem [BLOCK_SIZE];

        assign wr_acc  = rst_n & bus.write[i] & ~bus.full[i];
        assign rel_hit = bus.rel_len_dv && (bus.rel_block == BW'(i));
        assign rel_amt = !rel_hit ? '0 : ((bus.rel_len > cnt) ? cnt : bus.rel_len);
        assign rd_idx  = rd_ptr + bus.rd_addr;

        // A full release (L = BLOCK_SIZE) leaves the pointer unchanged, as wrapping requires.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt    <= '0;
            end else begin
                if (wr_acc) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                rd_ptr <= rd_ptr + rel_amt[AW-1:0];
                cnt    <= cnt + CW'(wr_acc) - rel_amt;
            end
        end

        always_ff @(posedge clk) begin
            if (wr_acc) begin
                mem[wr_ptr] <= bus.data_in[i*FW +: FW];
            end
        end

        assign full_loc[i]            = (cnt == CW'(BLOCK_SIZE));
        assign bus.empty[i]           = (cnt == '0);
        assign bus.status[i*CW +: CW] = cnt;
        assign cnt_all[i]             = cnt;

        if (LUT_MEMORY != 0) begin : g_lut
            assign rd_word[i] = mem[rd_idx];
        end else begin : g_bram
            logic [FW-1:0] rd_q;

            always_ff @(posedge clk) begin
                if (rd_ok && (bus.block_addr == BW'(i))) begin
                    rd_q <= mem[rd_idx];
                end
            end

            assign rd_word[i] = rd_q;
        end
    end

    assign bus.full = (GLOB_STATE != 0) ? {FLOWS{|full_loc}} : full_loc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_vld_q <= 1'b0;
        end else begin
            data_vld_q <= rd_ok;
        end
    end

    assign bus.data_vld = data_vld_q;

    if (LUT_MEMORY != 0) begin : g_out_lut
        logic [FW-1:0] data_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                data_q <= '0;
            end else if (rd_ok) begin
                data_q <= rd_word[bus.block_addr];
            end
        end

        assign bus.data_out = data_q;
    end else begin : g_out_bram
        // The RAM output register has no reset, so a "seen" flag forces zero until the first read.
        logic [BW-1:0] sel_q;
        logic          seen_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sel_q  <= '0;
                seen_q <= 1'b0;
            end else if (rd_ok) begin
                sel_q  <= bus.block_addr;
                seen_q <= 1'b1;
            end
        end

        assign bus.data_out = seen_q ? rd_word[sel_q] : '0;
    end
endmodule

// File: tb/tb_nfifo2mem.sv
// Directed bench for nfifo2mem: a queue of expected read data is consumed by
// a monitor on every DATA_VLD; flags and occupancy are checked directly.
module tb_nfifo2mem;
    localparam int DW    = 64;
    localparam int FLOWS = 8;
    localparam int BS    = 512;
    localparam int FW    = 8;
    localparam int AW    = 9;
    localparam int CW    = 10;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    logic [FW-1:0] exp_q [$];

    always #5 clk = ~clk;

    nfifo2mem_if #(.DATA_WIDTH(DW), .FLOWS(FLOWS), .BLOCK_SIZE(BS)) bus ();
    nfifo2mem_if #(.DATA_WIDTH(DW), .FLOWS(FLOWS), .BLOCK_SIZE(BS)) bus_g ();

    assign bus_g.data_in    = bus.data_in;
    assign bus_g.write      = bus.write;
    assign bus_g.block_addr = bus.block_addr;
    assign bus_g.rd_addr    = bus.rd_addr;
    assign bus_g.read       = bus.read;
    assign bus_g.rel_block  = bus.rel_block;
    assign bus_g.rel_len    = bus.rel_len;
    assign bus_g.rel_len_dv = bus.rel_len_dv;

    nfifo2mem #(.DATA_WIDTH(DW), .FLOWS(FLOWS), .BLOCK_SIZE(BS),
                .LUT_MEMORY(0), .GLOB_STATE(0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Second instance shares the stimulus to cover global backpressure and LUT storage.
    nfifo2mem #(.DATA_WIDTH(DW), .FLOWS(FLOWS), .BLOCK_SIZE(BS),
                .LUT_MEMORY(1), .GLOB_STATE(1)) dut_g (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_g.slave)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [FLOWS-1:0] wr, input logic [DW-1:0] din,
                                 input logic rd, input logic [2:0] baddr, input logic [AW-1:0] raddr,
                                 input logic rel, input logic [2:0] rblk, input logic [CW-1:0] rlen);
        bus.write      = wr;
        bus.data_in    = din;
        bus.read       = rd;
        bus.block_addr = baddr;
        bus.rd_addr    = raddr;
        bus.rel_len_dv = rel;
        bus.rel_block  = rblk;
        bus.rel_len    = rlen;
        @(posedge clk);
        #1;
        bus.write      = '0;
        bus.read       = 1'b0;
        bus.rel_len_dv = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        idle(1);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
    endtask

    function automatic logic [DW-1:0] at_flow(input int f, input logic [7:0] b);
        logic [DW-1:0] v;
        v = '0;
        v[f*FW +: FW] = b;
        return v;
    endfunction

    function automatic logic [31:0] flow_status(input int f);
        return 32'(bus.status[f*CW +: CW]);
    endfunction

    // Scoreboard monitor: every valid read must match the oldest expected word.
    always @(negedge clk) begin
        if (bus.data_vld) begin
            if (exp_q.size() == 0) begin
                checkOutput("spurious_vld", 32'(bus.data_vld), 32'd0);
            end else begin
                checkOutput("rd_data", 32'(bus.data_out), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] b0;
        logic [7:0] b1;
        rst_n          = 1'b0;
        bus.write      = '0;
        bus.data_in    = '0;
        bus.read       = 1'b0;
        bus.block_addr = '0;
        bus.rd_addr    = '0;
        bus.rel_len_dv = 1'b0;
        bus.rel_block  = '0;
        bus.rel_len    = '0;
        idle(2);

        checkOutput("rst_status", 32'(|bus.status), 32'd0);
        checkOutput("rst_empty", 32'(bus.empty), 32'hFF);
        checkOutput("rst_full", 32'(bus.full), 32'h00);
        checkOutput("rst_vld", 32'(bus.data_vld), 32'd0);
        checkOutput("rst_dout", 32'(bus.data_out), 32'h00);
        rst_n = 1'b1;
        idle(1);

        // Three writes on flow 2, then reads at several offsets.
        applyStimulus(8'h04, at_flow(2, 8'h11), 0, 0, 0, 0, 0, 0);
        applyStimulus(8'h04, at_flow(2, 8'h22), 0, 0, 0, 0, 0, 0);
        applyStimulus(8'h04, at_flow(2, 8'h33), 0, 0, 0, 0, 0, 0);
        checkOutput("f2_status", flow_status(2), 32'd3);
        checkOutput("f2_empty", 32'(bus.empty), 32'hFB);
        exp_q.push_back(8'h22);
        applyStimulus(8'h00, '0, 1, 3'd2, 9'd1, 0, 0, 0);
        applyStimulus(8'h00, '0, 1, 3'd2, 9'd3, 0, 0, 0);
        checkOutput("oor_vld", 32'(bus.data_vld), 32'd0);
        checkOutput("oor_hold", 32'(bus.data_out), 32'h22);
        exp_q.push_back(8'h11);
        applyStimulus(8'h00, '0, 1, 3'd2, 9'd0, 0, 0, 0);
        exp_q.push_back(8'h33);
        applyStimulus(8'h00, '0, 1, 3'd2, 9'd2, 0, 0, 0);
        applyStimulus(8'h00, '0, 1, 3'd4, 9'd0, 0, 0, 0);
        checkOutput("empty_flow_vld", 32'(bus.data_vld), 32'd0);

        // Flow 1: zero-length release is a no-op, oversize release clamps to cnt.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            b0 = 8'hA0 + 8'(k);
            applyStimulus(8'h02, at_flow(1, b0), 0, 0, 0, 0, 0, 0);
        end
        applyStimulus(8'h00, '0, 0, 0, 0, 1, 3'd1, 10'd0);
        checkOutput("rel0_status", flow_status(1), 32'd4);
        exp_q.push_back(8'hA3);
        applyStimulus(8'h00, '0, 1, 3'd1, 9'd3, 0, 0, 0);
        applyStimulus(8'h00, '0, 0, 0, 0, 1, 3'd1, 10'd9);
        checkOutput("rel9_status", flow_status(1), 32'd0);
        checkOutput("rel9_empty", 32'(bus.empty), 32'hFF);
        applyStimulus(8'h00, '0, 1, 3'd1, 9'd0, 0, 0, 0);
        checkOutput("rel9_rd_vld", 32'(bus.data_vld), 32'd0);

        // Flows 3 and 5 filled together; local vs global FULL.
        do_reset();
        for (int i = 0; i < BS; i++) begin
            b0 = i[7:0];
            b1 = ~b0;
            applyStimulus(8'h28, at_flow(5, b0) | at_flow(3, b1), 0, 0, 0, 0, 0, 0);
            if (i == BS - 2) begin
                checkOutput("pre_full", 32'(bus.full), 32'h00);
                checkOutput("pre_full_glob", 32'(bus_g.full), 32'h00);
            end
        end
        checkOutput("f5_status", flow_status(5), 32'd512);
        checkOutput("f_full", 32'(bus.full), 32'h28);
        checkOutput("f_full_glob", 32'(bus_g.full), 32'hFF);
        checkOutput("f_empty", 32'(bus.empty), 32'hD7);
        applyStimulus(8'h20, at_flow(5, 8'hEE), 0, 0, 0, 0, 0, 0);
        checkOutput("f5_513_status", flow_status(5), 32'd512);
        exp_q.push_back(8'h00);
        applyStimulus(8'h00, '0, 1, 3'd5, 9'd0, 0, 0, 0);
        exp_q.push_back(8'hFF);
        applyStimulus(8'h00, '0, 1, 3'd5, 9'd511, 0, 0, 0);
        checkOutput("glob_rd_vld", 32'(bus_g.data_vld), 32'd1);
        checkOutput("glob_rd_data", 32'(bus_g.data_out), 32'hFF);

        // Full flow 3: write rejected, release 1 and read of old head in the same cycle.
        exp_q.push_back(8'hFF);
        applyStimulus(8'h08, at_flow(3, 8'h77), 1, 3'd3, 9'd0, 1, 3'd3, 10'd1);
        checkOutput("f3_status", flow_status(3), 32'd511);
        checkOutput("f3_full", 32'(bus.full), 32'h20);
        checkOutput("f3_full_glob", 32'(bus_g.full), 32'hFF);
        exp_q.push_back(8'hFE);
        applyStimulus(8'h00, '0, 1, 3'd3, 9'd0, 0, 0, 0);

        // Flow 0: fill, release 500, write across the wrap point.
        do_reset();
        for (int i = 0; i < BS; i++) begin
            b0 = i[7:0];
            applyStimulus(8'h01, at_flow(0, b0), 0, 0, 0, 0, 0, 0);
        end
        applyStimulus(8'h00, '0, 0, 0, 0, 1, 3'd0, 10'd500);
        checkOutput("f0_rel_status", flow_status(0), 32'd12);
        for (int k = 0; k < 10; k++) begin
            b0 = 8'h80 + 8'(k);
            applyStimulus(8'h01, at_flow(0, b0), 0, 0, 0, 0, 0, 0);
        end
        checkOutput("f0_wrap_status", flow_status(0), 32'd22);
        exp_q.push_back(8'h80);
        applyStimulus(8'h00, '0, 1, 3'd0, 9'd12, 0, 0, 0);
        exp_q.push_back(8'hFF);
        applyStimulus(8'h00, '0, 1, 3'd0, 9'd11, 0, 0, 0);
        exp_q.push_back(8'h89);
        applyStimulus(8'h00, '0, 1, 3'd0, 9'd21, 0, 0, 0);
        exp_q.push_back(8'hF4);
        applyStimulus(8'h00, '0, 1, 3'd0, 9'd0, 0, 0, 0);
        applyStimulus(8'h00, '0, 1, 3'd0, 9'd22, 0, 0, 0);
        checkOutput("f0_oor_vld", 32'(bus.data_vld), 32'd0);
        applyStimulus(8'h01, at_flow(0, 8'h8A), 0, 0, 0, 0, 0, 0);
        exp_q.push_back(8'h8A);
        applyStimulus(8'h00, '0, 1, 3'd0, 9'd22, 0, 0, 0);
        idle(1);

        // Reset right after a valid read: the response must be discarded.
        applyStimulus(8'h00, '0, 1, 3'd0, 9'd1, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_vld", 32'(bus.data_vld), 32'd0);
        checkOutput("midrst_status", 32'(|bus.status), 32'd0);
        checkOutput("midrst_empty", 32'(bus.empty), 32'hFF);
        checkOutput("midrst_dout", 32'(bus.data_out), 32'h00);
        applyStimulus(8'hFF, {DW{1'b1}}, 1, 3'd0, 9'd0, 1, 3'd0, 10'd5);
        applyStimulus(8'hFF, {DW{1'b1}}, 1, 3'd0, 9'd0, 0, 0, 0);
        checkOutput("inrst_status", 32'(|bus.status), 32'd0);
        rst_n = 1'b1;
        idle(3);
        checkOutput("postrst_vld", 32'(bus.data_vld), 32'd0);
        checkOutput("postrst_empty", 32'(bus.empty), 32'hFF);

        checkOutput("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/nfifo2mem.md
NFIFO2MEM -- requirements
Module: nfifo2mem

Interface
REQ-001 DATA_WIDTH, 64, total input data width; flow slice width FW = DATA_WIDTH/FLOWS (8).
REQ-002 FLOWS, 8, number of input flows, power of two.
REQ-003 BLOCK_SIZE, 512, items per flow block, power of two; AW = log2(BLOCK_SIZE), CW = AW+1.
REQ-004 LUT_MEMORY, 0, storage type (0 = BRAM, 1 = distributed LUT); no functional or latency difference.
REQ-005 GLOB_STATE, 0, 1 = global backpressure (all FULL bits raised when any flow is full).
REQ-006 CLK  in  1  single clock; all logic on rising edge.
REQ-007 RESET  in  1  asynchronous, active-low reset.
REQ-008 DATA_IN  in  DATA_WIDTH  flow i data in bits [(i+1)*FW-1 : i*FW].
REQ-009 WRITE  in  FLOWS  per-flow write strobe.
REQ-010 FULL  out  FLOWS  per-flow full flag.
REQ-011 BLOCK_ADDR  in  log2(FLOWS)  flow selected for read.
REQ-012 RD_ADDR  in  AW  read offset relative to the selected flow's read pointer.
REQ-013 READ  in  1  read request.
REQ-014 DATA_OUT  out  FW  read data.
REQ-015 DATA_VLD  out  1  DATA_OUT valid.
REQ-016 REL_BLOCK  in  log2(FLOWS)  flow selected for release.
REQ-017 REL_LEN  in  CW  number of items to release.
REQ-018 REL_LEN_DV  in  1  release strobe.
REQ-019 EMPTY  out  FLOWS  per-flow empty flag.
REQ-020 STATUS  out  FLOWS*CW  per-flow occupancy; flow i in bits [(i+1)*CW-1 : i*CW].

Function
REQ-021 Each flow SHALL own a private circular block of BLOCK_SIZE x FW with registers wr_ptr (AW), rd_ptr (AW) and cnt (CW).
REQ-022 A write on flow i SHALL occur when WRITE(i)=1 and FULL(i)=0: store slice at wr_ptr, wr_ptr+1 mod BLOCK_SIZE, cnt+1; all flows MAY write in the same cycle.
REQ-023 WRITE(i)=1 while FULL(i)=1 SHALL be ignored, with no state change.
REQ-024 FULL(i) SHALL be 1 iff cnt(i)=BLOCK_SIZE; if GLOB_STATE=1, all FULL bits SHALL be 1 iff any cnt=BLOCK_SIZE.
REQ-025 EMPTY(i) SHALL be 1 iff cnt(i)=0; STATUS SHALL equal cnt directly from registers.
REQ-026 A read SHALL access address (rd_ptr(BLOCK_ADDR)+RD_ADDR) mod BLOCK_SIZE.
REQ-027 Read latency SHALL be 1 cycle: DATA_VLD=1 with DATA_OUT in the cycle after READ=1, only if RD_ADDR < cnt(BLOCK_ADDR) at request time.
REQ-028 An out-of-range read SHALL produce DATA_VLD=0 in the following cycle.
REQ-029 DATA_OUT SHALL hold its last value whenever DATA_VLD=0.
REQ-030 A release with REL_LEN_DV=1 SHALL advance rd_ptr(REL_BLOCK) by L mod BLOCK_SIZE and decrease cnt by L, where L = min(REL_LEN, cnt).
REQ-031 A release with REL_LEN=0 SHALL cause no state change.
REQ-032 Write and release on the same flow in the same cycle SHALL yield cnt_next = cnt + w - L, where w is the accepted write (0/1).
REQ-033 FULL/EMPTY/read-range checks SHALL use pre-cycle cnt; data written in cycle t SHALL be readable from cycle t+1.
REQ-034 A read and a release on the same flow in the same cycle SHALL use the pre-release rd_ptr.
REQ-035 Pointers SHALL wrap from BLOCK_SIZE-1 to 0 without gaps.

Reset
REQ-036 RESET=0 SHALL immediately clear every wr_ptr, rd_ptr and cnt, set FULL=0, EMPTY=all ones, STATUS=0, DATA_VLD=0 and DATA_OUT=0; memory contents are undefined.
REQ-037 Reset asserted mid-operation SHALL discard in-flight reads (no DATA_VLD after deassertion) and SHALL ignore all inputs while RESET=0.

Verification
REQ-038 Write 0x11,0x22,0x33 on flow 2 -> STATUS flow2=3, EMPTY(2)=0; READ BLOCK_ADDR=2 RD_ADDR=1 -> next cycle DATA_VLD=1, DATA_OUT=0x22.
REQ-039 512 writes on flow 5 -> FULL(5)=1, 513th write ignored; with GLOB_STATE=1, FULL=0xFF.
REQ-040 Fill flow 0, release 500, write 10 -> wr_ptr wrapped to 10, cnt=22; read RD_ADDR=12 returns the first post-wrap item.
REQ-041 cnt=4 on flow 1, REL_LEN=9 -> cnt=0, EMPTY(1)=1; a subsequent READ RD_ADDR=0 -> DATA_VLD=0.
REQ-042 Flow 3 full, in the same cycle WRITE(3)=1 and release of 1 -> write rejected, cnt=511, FULL(3)=0 next cycle.
REQ-043 Assert RESET=0 the cycle after a valid READ -> DATA_VLD=0, STATUS=0, EMPTY=0xFF immediately, with no spurious DATA_VLD after release of reset.
